// File: rtl/conv_channel_seq.sv
// Job sequencer for one ConvChannel: clear, weight load, settle gap, pixel stream, result drain.
// Upstream weight/pixel strobes are gated so ConvChannel only sees beats in the matching phase.
module conv_channel_seq #(
  parameter int unsigned KernelSize   = 9,
  parameter int unsigned ClrCycles    = 2,
  parameter int unsigned GapCycles    = 4,
  parameter int unsigned DrainTimeout = 255
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       job_valid,
  output logic       job_ready,
  input  logic [8:0] job_row,
  input  logic [8:0] job_col,
  input  logic       w_valid,
  output logic       w_ready,
  input  logic       d_valid,
  output logic       d_ready,
  output logic       conv_rst,
  output logic [8:0] conv_row,
  output logic [8:0] conv_col,
  output logic       conv_weight_valid,
  output logic       conv_data_valid,
  input  logic       conv_result_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned DimW  = 9;
  localparam int unsigned NpixW = 18;
  localparam int unsigned WcntW = $clog2(KernelSize + 1);
  localparam int unsigned PhMax = (ClrCycles > GapCycles) ? ClrCycles : GapCycles;
  localparam int unsigned PhW   = $clog2(PhMax + 1);
  localparam int unsigned TmrW  = $clog2(DrainTimeout + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_WLOAD = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d;
  logic [NpixW-1:0] pcnt_q, pcnt_d;
  logic [NpixW-1:0] rcnt_q, rcnt_d;
  logic [NpixW-1:0] npix_q, npix_d;
  logic [PhW-1:0]   ph_q, ph_d;
  logic [TmrW-1:0]  timer_q, timer_d;
  logic [DimW-1:0]  row_q, row_d;
  logic [DimW-1:0]  col_q, col_d;
  logic             err_q, err_d;

  logic             res_hit;
  logic [NpixW-1:0] rcnt_inc;

  // Results are only meaningful while pixels are in flight or draining.
  assign res_hit  = ((state_q == S_DATA) || (state_q == S_DRAIN)) && conv_result_ready;
  assign rcnt_inc = rcnt_q + NpixW'(res_hit);

  // Phase decode; valids pass straight through only in their own phase.
  assign job_ready         = (state_q == S_IDLE);
  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign err               = (state_q == S_DONE) && err_q;
  assign conv_rst          = Rst || (state_q == S_CLEAR);
  assign w_ready           = (state_q == S_WLOAD);
  assign d_ready           = (state_q == S_DATA);
  assign conv_weight_valid = w_ready && w_valid;
  assign conv_data_valid   = d_ready && d_valid;
  assign conv_row          = row_q;
  assign conv_col          = col_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      pcnt_q  <= '0;
      rcnt_q  <= '0;
      npix_q  <= '0;
      ph_q    <= '0;
      timer_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      pcnt_q  <= pcnt_d;
      rcnt_q  <= rcnt_d;
      npix_q  <= npix_d;
      ph_q    <= ph_d;
      timer_q <= timer_d;
      row_q   <= row_d;
      col_q   <= col_d;
      err_q   <= err_d;
    end
  end

  // Next-state and counter logic; the drain timer only runs while waiting in DRAIN.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pcnt_d  = pcnt_q;
    rcnt_d  = rcnt_q;
    npix_d  = npix_q;
    ph_d    = ph_q;
    timer_d = '0;
    row_d   = row_q;
    col_d   = col_q;
    err_d   = err_q;

    if (res_hit) rcnt_d = rcnt_inc;

    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          row_d  = job_row;
          col_d  = job_col;
          npix_d = NpixW'(job_row) * NpixW'(job_col);
          wcnt_d = '0;
          pcnt_d = '0;
          rcnt_d = '0;
          ph_d   = '0;
          if ((job_row == '0) || (job_col == '0)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        if (ph_q == PhW'(ClrCycles - 1)) begin
          ph_d    = '0;
          state_d = S_WLOAD;
        end else begin
          ph_d = ph_q + PhW'(1);
        end
      end
      S_WLOAD: begin
        if (w_valid) begin
          wcnt_d = wcnt_q + WcntW'(1);
          if (wcnt_q == WcntW'(KernelSize - 1)) state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (ph_q == PhW'(GapCycles - 1)) begin
          ph_d    = '0;
          state_d = S_DATA;
        end else begin
          ph_d = ph_q + PhW'(1);
        end
      end
      S_DATA: begin
        if (d_valid) begin
          pcnt_d = pcnt_q + NpixW'(1);
          if (pcnt_q == npix_q - NpixW'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rcnt_inc >= npix_q) begin
          state_d = S_DONE;
        end else if (!res_hit) begin
          timer_d = timer_q + TmrW'(1);
          if (timer_d == TmrW'(DrainTimeout)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_channel_seq.sv
// Directed bench for conv_channel_seq: table of jobs with hand-computed phase counts,
// plus reset-state and mid-job reset sequences.
module tb_conv_channel_seq;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       job_valid;
  logic       job_ready;
  logic [8:0] job_row;
  logic [8:0] job_col;
  logic       w_valid;
  logic       w_ready;
  logic       d_valid;
  logic       d_ready;
  logic       conv_rst;
  logic [8:0] conv_row;
  logic [8:0] conv_col;
  logic       conv_weight_valid;
  logic       conv_data_valid;
  logic       conv_result_ready;
  logic       busy;
  logic       done;
  logic       err;

  conv_channel_seq dut (
    .Clk               (Clk),
    .Rst               (Rst),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .job_row           (job_row),
    .job_col           (job_col),
    .w_valid           (w_valid),
    .w_ready           (w_ready),
    .d_valid           (d_valid),
    .d_ready           (d_ready),
    .conv_rst          (conv_rst),
    .conv_row          (conv_row),
    .conv_col          (conv_col),
    .conv_weight_valid (conv_weight_valid),
    .conv_data_valid   (conv_data_valid),
    .conv_result_ready (conv_result_ready),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  always #5 Clk = ~Clk;

  // rmode 0: results one per cycle after the pixel stream; 1: result alongside each pixel beat.
  // chain: after accept, keep job_valid high with the next entry's job.
  // lag: cycles from last result (or accept if none) to the done cycle.
  typedef struct {
    int row;
    int col;
    int bub;
    int rmode;
    int nres;
    int chain;
    int abort_at;
    int exp_clr;
    int exp_w;
    int exp_gap;
    int exp_d;
    int exp_err;
    int exp_lag;
  } vec_t;

  localparam int NVEC = 8;
  vec_t tbl[NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic run_job(input int k);
    vec_t v;
    int clr, wb, gap, db, rg, vmis, acc_cyc, last_res, done_cyc, errv, row_o, col_o, npix, ref_cyc, dn;
    bit wt, dt, aborted;
    v = tbl[k];
    clr = 0; wb = 0; gap = 0; db = 0; rg = 0; vmis = 0;
    acc_cyc = -1; last_res = -1; done_cyc = -1; errv = 0; row_o = -1; col_o = -1;
    npix = v.row * v.col;
    wt = 1'b1; dt = 1'b1; aborted = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge Clk);
      #1;
      if (v.abort_at > 0 && db == v.abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (acc_cyc < 0) begin
        job_valid = 1'b1;
        job_row   = 9'(v.row);
        job_col   = 9'(v.col);
      end else if (v.chain != 0 && k + 1 < NVEC) begin
        job_valid = 1'b1;
        job_row   = 9'(tbl[k+1].row);
        job_col   = 9'(tbl[k+1].col);
      end else begin
        job_valid = 1'b0;
      end
      if (v.bub != 0) begin
        wt = ~wt;
        dt = ~dt;
      end
      w_valid = wt;
      d_valid = dt;
      if (v.rmode == 0) conv_result_ready = (db == npix) && (rg < v.nres);
      else              conv_result_ready = d_valid && d_ready && (rg < v.nres);
      @(negedge Clk);
      if (acc_cyc < 0 && job_valid && job_ready) acc_cyc = cyc;
      if (conv_rst) clr++;
      if (w_valid && w_ready) wb++;
      if (busy && !conv_rst && !w_ready && !d_ready && wb > 0 && db == 0) gap++;
      if (d_valid && d_ready) db++;
      if (conv_result_ready) begin
        rg++;
        last_res = cyc;
      end
      if (conv_weight_valid != (w_valid && w_ready)) vmis++;
      if (conv_data_valid != (d_valid && d_ready)) vmis++;
      if (w_ready && d_ready) vmis++;
      if (job_ready == busy) vmis++;
      if (err && !done) vmis++;
      if (done) begin
        done_cyc = cyc;
        errv     = int'(err);
        row_o    = int'(conv_row);
        col_o    = int'(conv_col);
        break;
      end
    end

    if (aborted) begin
      // Asynchronous reset mid-stream: outputs react without waiting for a clock edge.
      Rst = 1'b1;
      #1;
      check($sformatf("job%0d_abort_busy", k), int'(busy), 0);
      check($sformatf("job%0d_abort_conv_rst", k), int'(conv_rst), 1);
      job_valid = 1'b0;
      conv_result_ready = 1'b0;
      dn = 0;
      repeat (3) begin
        @(negedge Clk);
        if (done || err) dn++;
      end
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      repeat (6) begin
        @(negedge Clk);
        if (done || err || busy || conv_rst) dn++;
      end
      check($sformatf("job%0d_abort_quiet", k), dn, 0);
      check($sformatf("job%0d_abort_vmis", k), vmis, 0);
      return;
    end

    conv_result_ready = 1'b0;
    ref_cyc = (last_res >= 0) ? last_res : acc_cyc;
    check($sformatf("job%0d_done_seen", k), int'(done_cyc >= 0), 1);
    check($sformatf("job%0d_accept_cycle", k), acc_cyc, 0);
    check($sformatf("job%0d_conv_rst_cycles", k), clr, v.exp_clr);
    check($sformatf("job%0d_weight_beats", k), wb, v.exp_w);
    check($sformatf("job%0d_gap_cycles", k), gap, v.exp_gap);
    check($sformatf("job%0d_data_beats", k), db, v.exp_d);
    check($sformatf("job%0d_err", k), errv, v.exp_err);
    check($sformatf("job%0d_conv_row", k), row_o, v.row);
    check($sformatf("job%0d_conv_col", k), col_o, v.col);
    check($sformatf("job%0d_done_lag", k), done_cyc - ref_cyc, v.exp_lag);
    check($sformatf("job%0d_phase_gating", k), vmis, 0);
  endtask

  initial begin
    //          row col bub rm nres ch abort clr w  gap d   err lag
    tbl[0] = '{6,  6,  0,  0, 36,  1, 0,    2,  9, 4, 36, 0,  1};   // 6x6, back-to-back into 4x4
    tbl[1] = '{4,  4,  0,  1, 16,  0, 0,    2,  9, 4, 16, 0,  2};   // results done before DRAIN
    tbl[2] = '{3,  5,  1,  0, 15,  0, 0,    2,  9, 4, 15, 0,  1};   // bubbles on both streams
    tbl[3] = '{0,  5,  0,  0, 0,   0, 0,    0,  0, 0, 0,  1,  1};   // zero dimension
    tbl[4] = '{6,  6,  0,  0, 30,  0, 0,    2,  9, 4, 36, 1,  256}; // 255 result-free cycles, then done
    tbl[5] = '{1,  1,  0,  0, 1,   0, 0,    2,  9, 4, 1,  0,  1};   // single pixel
    tbl[6] = '{6,  6,  0,  0, 36,  0, 10,   0,  0, 0, 0,  0,  0};   // reset at data beat 10
    tbl[7] = '{6,  6,  0,  0, 36,  0, 0,    2,  9, 4, 36, 0,  1};   // clean job after abort

    Rst = 1'b1;
    job_valid = 1'b0;
    job_row = '0;
    job_col = '0;
    w_valid = 1'b1;
    d_valid = 1'b1;
    conv_result_ready = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("reset_conv_rst", int'(conv_rst), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    check("reset_conv_row", int'(conv_row), 0);
    check("reset_conv_col", int'(conv_col), 0);
    check("reset_wvalid_gated", int'(conv_weight_valid), 0);
    check("reset_dvalid_gated", int'(conv_data_valid), 0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(negedge Clk);
    check("idle_conv_rst_low", int'(conv_rst), 0);
    check("idle_job_ready", int'(job_ready), 1);

    for (int k = 0; k < NVEC; k++) run_job(k);

    @(negedge Clk);
    check("final_busy_dropped", int'(busy), 0);
    check("final_done_low", int'(done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
